// File: rtl/reg_arb_pkg.sv
// ============================================================================
// Module      : reg_arb_pkg
// Description : Shared widths, requester indices and write-request type for
//               the register-file write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_arb_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 5;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

`default_nettype wire

// File: rtl/reg_wr_fifo.sv
// ============================================================================
// Module      : reg_wr_fifo
// Description : Two-entry write-request queue with push, pop, head and count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_wr_fifo
    import reg_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  wr_req_t    push_data,
    input  logic       pop,
    output wr_req_t    head,
    output logic [1:0] count
);

    wr_req_t    r_mem [2];
    logic       r_rd_ptr;
    logic       r_wr_ptr;
    logic [1:0] r_count;
    logic       w_push_ok;
    logic       w_pop_ok;

    assign w_push_ok = push && (r_count != 2'd2);
    assign w_pop_ok  = pop  && (r_count != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Round-robin arbiter sharing one register-file write port
//               between ALU and load writeback. Optional REGARB_R0_DISCARD_EN
//               suppresses writes to address 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wr_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [DATA_W-1:0] Rdst,
    output logic [ADDR_W-1:0] Rdst_addr,
    output logic              Rwrite,
    output logic              busy
);
    import reg_arb_pkg::*;

    wr_req_t    w_in    [2];
    wr_req_t    w_head  [2];
    logic [1:0] w_count [2];
    logic [1:0] w_pop;
    logic [1:0] w_hv;
    logic       w_gnt_vld;
    logic       w_gnt_sel;
    logic       w_do_write;
    wr_req_t    w_sel;
    logic       r_last_grant;

    assign w_in[REQ_ALU]  = '{addr: req_addr0, data: req_data0};
    assign w_in[REQ_LOAD] = '{addr: req_addr1, data: req_data1};

    for (genvar i = 0; i < 2; i++) begin : g_queue
        // Ready depends on occupancy alone, never on this cycle's pop.
        assign req_ready[i] = (w_count[i] != 2'(QDEPTH));

        reg_wr_fifo u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (req_valid[i] & req_ready[i]),
            .push_data (w_in[i]),
            .pop       (w_pop[i]),
            .head      (w_head[i]),
            .count     (w_count[i])
        );
    end

    always_comb begin
        w_hv      = {(w_count[REQ_LOAD] != 2'd0), (w_count[REQ_ALU] != 2'd0)};
        w_gnt_vld = |w_hv;
        w_gnt_sel = (&w_hv) ? ~r_last_grant : w_hv[REQ_LOAD];
        w_pop     = 2'b00;
        if (w_gnt_vld) begin
            w_pop[w_gnt_sel] = 1'b1;
        end
        w_sel = w_gnt_sel ? w_head[REQ_LOAD] : w_head[REQ_ALU];
`ifdef REGARB_R0_DISCARD_EN
        // R0 is hardwired zero: the entry still drains and counts as a grant.
        w_do_write = w_gnt_vld && (w_sel.addr != '0);
`else
        w_do_write = w_gnt_vld;
`endif
    end

    // Address/data only move alongside a strobe, keeping the level-sensitive
    // register file free of glitches while Rwrite is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Rwrite       <= 1'b0;
            Rdst         <= '0;
            Rdst_addr    <= '0;
            r_last_grant <= 1'b1;
        end else begin
            Rwrite <= w_do_write;
            if (w_do_write) begin
                Rdst      <= w_sel.data;
                Rdst_addr <= w_sel.addr;
            end
            if (w_gnt_vld) begin
                r_last_grant <= w_gnt_sel;
            end
        end
    end

    assign busy = (w_count[REQ_ALU] != 2'd0) | (w_count[REQ_LOAD] != 2'd0) | Rwrite;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
// ============================================================================
// Module      : tb_regfile_wr_arbiter
// Description : Directed self-checking bench for regfile_wr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [4:0]  req_addr0 = '0;
    logic [4:0]  req_addr1 = '0;
    logic [15:0] req_data0 = '0;
    logic [15:0] req_data1 = '0;
    logic [15:0] Rdst;
    logic [4:0]  Rdst_addr;
    logic        Rwrite;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    wr_t         wlog [$];
    logic [15:0] rf [32];

    regfile_wr_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr0 (req_addr0),
        .req_addr1 (req_addr1),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .Rdst      (Rdst),
        .Rdst_addr (Rdst_addr),
        .Rwrite    (Rwrite),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Level-sensitive register file model plus a log of every write strobe.
    always @(negedge clk) begin
        if (rst_n && Rwrite) begin
            wlog.push_back('{Rdst_addr, Rdst, cyc});
            rf[Rdst_addr] = Rdst;
        end
    end

    function automatic logic [4:0] log_addr(int k);
        return (k < wlog.size()) ? wlog[k].addr : 5'bx;
    endfunction

    function automatic logic [15:0] log_data(int k);
        return (k < wlog.size()) ? wlog[k].data : 16'bx;
    endfunction

    function automatic int log_cyc(int k);
        return (k < wlog.size()) ? wlog[k].cyc : -100;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 2'b00;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        vectors++;
        if (req_ready !== 2'b11) begin miscompares++; $display("FAIL reset_ready: got %b expected %b", req_ready, 2'b11); end
        vectors++;
        if (Rwrite !== 1'b0) begin miscompares++; $display("FAIL reset_rwrite: got %b expected %b", Rwrite, 1'b0); end
        vectors++;
        if (Rdst !== 16'd0) begin miscompares++; $display("FAIL reset_rdst: got %0d expected %0d", Rdst, 0); end
        vectors++;
        if (Rdst_addr !== 5'd0) begin miscompares++; $display("FAIL reset_rdst_addr: got %0d expected %0d", Rdst_addr, 0); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        wlog.delete();
        req_addr0 = 5'd1;
        req_data0 = 16'd47;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        vectors++;
        if (Rwrite !== 1'b0) begin miscompares++; $display("FAIL single_early_rwrite: got %b expected %b", Rwrite, 1'b0); end
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_queued: got %b expected %b", busy, 1'b1); end
        tick();
        vectors++;
        if (Rwrite !== 1'b1) begin miscompares++; $display("FAIL single_rwrite: got %b expected %b", Rwrite, 1'b1); end
        vectors++;
        if (Rdst_addr !== 5'd1) begin miscompares++; $display("FAIL single_addr: got %0d expected %0d", Rdst_addr, 1); end
        vectors++;
        if (Rdst !== 16'd47) begin miscompares++; $display("FAIL single_data: got %0d expected %0d", Rdst, 47); end
        tick();
        vectors++;
        if (Rwrite !== 1'b0) begin miscompares++; $display("FAIL single_strobe_len: got %b expected %b", Rwrite, 1'b0); end
        vectors++;
        if (Rdst_addr !== 5'd1) begin miscompares++; $display("FAIL single_addr_hold: got %0d expected %0d", Rdst_addr, 1); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_idle: got %b expected %b", busy, 1'b0); end
        vectors++;
        if (wlog.size() !== 1) begin miscompares++; $display("FAIL single_count: got %0d expected %0d", wlog.size(), 1); end
        vectors++;
        if (rf[1] !== 16'd47) begin miscompares++; $display("FAIL single_rf_r1: got %0d expected %0d", rf[1], 47); end
    endtask

    task automatic test_tie();
        do_reset();
        wlog.delete();
        req_addr0 = 5'd2;
        req_data0 = 16'd74;
        req_addr1 = 5'd3;
        req_data1 = 16'd99;
        req_valid = 2'b11;
        tick();
        req_valid = 2'b00;
        repeat (4) tick();
        vectors++;
        if (wlog.size() !== 2) begin miscompares++; $display("FAIL tie_count: got %0d expected %0d", wlog.size(), 2); end
        vectors++;
        if (log_addr(0) !== 5'd2 || log_data(0) !== 16'd74) begin
            miscompares++; $display("FAIL tie_first: got addr %0d data %0d expected addr 2 data 74", log_addr(0), log_data(0));
        end
        vectors++;
        if (log_addr(1) !== 5'd3 || log_data(1) !== 16'd99) begin
            miscompares++; $display("FAIL tie_second: got addr %0d data %0d expected addr 3 data 99", log_addr(1), log_data(1));
        end
        vectors++;
        if (log_cyc(1) !== log_cyc(0) + 1) begin
            miscompares++; $display("FAIL tie_spacing: got cycle %0d expected %0d", log_cyc(1), log_cyc(0) + 1);
        end
        vectors++;
        if (rf[2] !== 16'd74 || rf[3] !== 16'd99) begin
            miscompares++; $display("FAIL tie_rf: got R2=%0d R3=%0d expected R2=74 R3=99", rf[2], rf[3]);
        end
    endtask

    task automatic test_round_robin();
        int s0 = 0;
        int s1 = 0;
        int guard = 0;
        wlog.delete();
        while ((s0 < 4 || s1 < 4) && guard < 40) begin
            req_valid = 2'b00;
            if (s0 < 4) begin
                req_valid[0] = 1'b1;
                req_addr0 = 5'(8 + s0);
                req_data0 = 16'(100 + s0);
                if (req_ready[0]) s0++;
            end
            if (s1 < 4) begin
                req_valid[1] = 1'b1;
                req_addr1 = 5'(16 + s1);
                req_data1 = 16'(200 + s1);
                if (req_ready[1]) s1++;
            end
            tick();
            guard++;
        end
        req_valid = 2'b00;
        vectors++;
        if (guard >= 40) begin miscompares++; $display("FAIL rr_stream_timeout: got %0d cycles expected under %0d", guard, 40); end
        repeat (6) tick();
        vectors++;
        if (wlog.size() !== 8) begin miscompares++; $display("FAIL rr_count: got %0d expected %0d", wlog.size(), 8); end
        for (int k = 0; k < 8; k++) begin
            logic [4:0]  ea;
            logic [15:0] ed;
            ea = (k % 2 == 0) ? 5'(8 + k / 2) : 5'(16 + k / 2);
            ed = (k % 2 == 0) ? 16'(100 + k / 2) : 16'(200 + k / 2);
            vectors++;
            if (log_addr(k) !== ea || log_data(k) !== ed) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: got addr %0d data %0d expected addr %0d data %0d", k, log_addr(k), log_data(k), ea, ed);
            end
        end
        vectors++;
        if (log_cyc(7) !== log_cyc(0) + 7) begin
            miscompares++; $display("FAIL rr_consecutive: got span %0d expected %0d", log_cyc(7) - log_cyc(0), 7);
        end
    endtask

    task automatic test_backpressure();
        int s0 = 0;
        int s1 = 0;
        int guard = 0;
        int n0 = 0;
        int n1 = 0;
        bit saw_low0 = 1'b0;
        bit order_ok = 1'b1;
        do_reset();
        wlog.delete();
        while ((s0 < 3 || s1 < 6) && guard < 40) begin
            req_valid = 2'b00;
            if (req_ready[0] === 1'b0) saw_low0 = 1'b1;
            if (s0 < 3) begin
                req_valid[0] = 1'b1;
                req_addr0 = 5'(4 + s0);
                req_data0 = 16'(400 + s0);
                if (req_ready[0]) s0++;
            end
            if (s1 < 6) begin
                req_valid[1] = 1'b1;
                req_addr1 = 5'(20 + s1);
                req_data1 = 16'(300 + s1);
                if (req_ready[1]) s1++;
            end
            tick();
            guard++;
        end
        req_valid = 2'b00;
        vectors++;
        if (guard >= 40) begin miscompares++; $display("FAIL bp_stream_timeout: got %0d cycles expected under %0d", guard, 40); end
        repeat (8) tick();
        vectors++;
        if (saw_low0 !== 1'b1) begin miscompares++; $display("FAIL bp_ready_drop: got %b expected %b", saw_low0, 1'b1); end
        vectors++;
        if (req_ready !== 2'b11) begin miscompares++; $display("FAIL bp_ready_recover: got %b expected %b", req_ready, 2'b11); end
        for (int k = 0; k < wlog.size(); k++) begin
            if (log_addr(k) < 5'd20) begin
                if (log_addr(k) !== 5'(4 + n0) || log_data(k) !== 16'(400 + n0)) order_ok = 1'b0;
                n0++;
            end else begin
                if (log_addr(k) !== 5'(20 + n1) || log_data(k) !== 16'(300 + n1)) order_ok = 1'b0;
                n1++;
            end
        end
        vectors++;
        if (n0 !== 3 || n1 !== 6) begin miscompares++; $display("FAIL bp_counts: got %0d/%0d expected 3/6", n0, n1); end
        vectors++;
        if (order_ok !== 1'b1) begin miscompares++; $display("FAIL bp_order: got %b expected %b", order_ok, 1'b1); end
        vectors++;
        if (rf[6] !== 16'd402) begin miscompares++; $display("FAIL bp_rf_r6: got %0d expected %0d", rf[6], 402); end
    endtask

    task automatic test_reset_mid();
        int n;
        req_addr0 = 5'd9;  req_data0 = 16'd1;
        req_addr1 = 5'd10; req_data1 = 16'd2;
        req_valid = 2'b11;
        tick();
        req_addr0 = 5'd11; req_data0 = 16'd3;
        req_addr1 = 5'd12; req_data1 = 16'd4;
        tick();
        req_valid = 2'b00;
        vectors++;
        if (Rwrite !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_rwrite: got %b expected %b", Rwrite, 1'b1); end
        #1;
        rst_n = 1'b0;
        #1;
        n = wlog.size();
        vectors++;
        if (Rwrite !== 1'b0) begin miscompares++; $display("FAIL rstmid_rwrite: got %b expected %b", Rwrite, 1'b0); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b expected %b", busy, 1'b0); end
        vectors++;
        if (req_ready !== 2'b11) begin miscompares++; $display("FAIL rstmid_ready: got %b expected %b", req_ready, 2'b11); end
        vectors++;
        if (Rdst_addr !== 5'd0 || Rdst !== 16'd0) begin
            miscompares++; $display("FAIL rstmid_outputs: got addr %0d data %0d expected 0 0", Rdst_addr, Rdst);
        end
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        vectors++;
        if (wlog.size() !== n) begin miscompares++; $display("FAIL rstmid_no_write: got %0d writes expected %0d", wlog.size(), n); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy_after: got %b expected %b", busy, 1'b0); end
    endtask

    task automatic test_r0_discard();
        do_reset();
        wlog.delete();
        req_addr0 = 5'd0;
        req_data0 = 16'd123;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        vectors++;
        if (req_ready !== 2'b11) begin miscompares++; $display("FAIL r0_ready: got %b expected %b", req_ready, 2'b11); end
`ifdef REGARB_R0_DISCARD_EN
        vectors++;
        if (Rwrite !== 1'b0) begin miscompares++; $display("FAIL r0_rwrite: got %b expected %b", Rwrite, 1'b0); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL r0_busy: got %b expected %b", busy, 1'b0); end
        vectors++;
        if (Rdst !== 16'd0) begin miscompares++; $display("FAIL r0_hold_data: got %0d expected %0d", Rdst, 0); end
        tick();
        vectors++;
        if (wlog.size() !== 0) begin miscompares++; $display("FAIL r0_count: got %0d expected %0d", wlog.size(), 0); end
`else
        vectors++;
        if (Rwrite !== 1'b1) begin miscompares++; $display("FAIL r0_rwrite: got %b expected %b", Rwrite, 1'b1); end
        vectors++;
        if (Rdst_addr !== 5'd0) begin miscompares++; $display("FAIL r0_addr: got %0d expected %0d", Rdst_addr, 0); end
        vectors++;
        if (Rdst !== 16'd123) begin miscompares++; $display("FAIL r0_data: got %0d expected %0d", Rdst, 123); end
        tick();
        vectors++;
        if (wlog.size() !== 1) begin miscompares++; $display("FAIL r0_count: got %0d expected %0d", wlog.size(), 1); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 16'd0;
        test_reset();
        test_single_write();
        test_tie();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_r0_discard();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
